// File: rtl/disp_spi_pkg.sv
// disp_spi_pkg
// Shared definitions for the display SPI master: segment command codes
// (identical to the display's SPI decode), the master FSM state type,
// the frame length and a helper that builds the on-wire frame word.
package disp_spi_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [2:0] SPI_CMD_NONE = 3'd0;
    localparam logic [2:0] SEGMENT_0    = 3'd1;
    localparam logic [2:0] SEGMENT_1    = 3'd2;
    localparam logic [2:0] SEGMENT_2    = 3'd3;
    localparam logic [2:0] SEGMENT_3    = 3'd4;
    localparam logic [2:0] SEGMENT_4    = 3'd5;
    localparam logic [2:0] SEGMENT_5    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_GAP
    } spi_state_e;

    // Command byte then data byte, both zero-padded, sent MSB first.
    function automatic logic [FRAME_BITS-1:0] spi_frame(input logic [2:0] c,
                                                        input logic [3:0] d);
        return {5'b0, c, 4'b0, d};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick
// Loadable down-counter that measures one SCK half-period of DIV cycles.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   load  in  restart the half-period (counter := DIV-1)
//   tick  out high during the last cycle of the half-period
// The counter parks at zero instead of wrapping, so tick stays high until
// the next load; the FSM loads on every phase change.
module spi_half_tick #(
    parameter int DIV = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/disp_spi_master.sv
// disp_spi_master
// SPI mode-0 master for the six-digit hex display. Each accepted
// (cmd, data) request becomes one 16-bit frame: {5'b0,cmd} then {4'b0,data}.
// Ports:
//   CLK_12_MHZ in  system clock
//   RST_N      in  asynchronous active-low reset
//   cmd_valid  in  request present
//   cmd_ready  out idle; request taken when cmd_valid && cmd_ready
//   cmd        in  segment command (1..6 = SEGMENT_0..5, 0 = none)
//   data       in  hex nibble for the selected digit
//   sck        out SPI clock, idles low
//   mosi       out SPI data, MSB first
//   ssel       out slave select, active low
//   miso       in  SPI data in
//   rx_data    out byte captured during the data byte of the last frame
//   done       out one-cycle pulse at frame completion
module disp_spi_master
    import disp_spi_pkg::*;
#(
    parameter int DIV = 6,
    parameter int GAP = 12
) (
    input  logic       CLK_12_MHZ,
    input  logic       RST_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [3:0] data,
    output logic       sck,
    output logic       mosi,
    output logic       ssel,
    input  logic       miso,
    output logic [7:0] rx_data,
    output logic       done
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    spi_state_e            state_q, state_d;
    // Bits still to send after the one currently on mosi.
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] frame;
    logic [7:0]            rx_sh_q, rx_sh_d;
    logic [3:0]            bit_q, bit_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  ready_q, ready_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic                  ssel_q, ssel_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  done_q, done_d;
    logic                  tick_load;
    logic                  tick;

    spi_half_tick #(.DIV(DIV)) u_half_tick (
        .clk   (CLK_12_MHZ),
        .rst_n (RST_N),
        .load  (tick_load),
        .tick  (tick)
    );

    assign frame = spi_frame(cmd, data);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        ready_d   = ready_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ssel_d    = ssel_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        tick_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    mosi_d    = frame[FRAME_BITS-1];
                    tx_d      = {frame[FRAME_BITS-2:0], 1'b0};
                    ssel_d    = 1'b0;
                    ready_d   = 1'b0;
                    bit_d     = 4'(FRAME_BITS - 1);
                    tick_load = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sck_d     = 1'b1;
                    tick_load = 1'b1;
                    state_d   = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                // Sample miso at the end of the high phase, then present the
                // next bit together with the falling edge.
                if (tick) begin
                    rx_sh_d   = {rx_sh_q[6:0], miso};
                    mosi_d    = tx_q[FRAME_BITS-1];
                    tx_d      = {tx_q[FRAME_BITS-2:0], 1'b0};
                    sck_d     = 1'b0;
                    tick_load = 1'b1;
                    state_d   = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    if (bit_q == 4'd0) begin
                        ssel_d    = 1'b1;
                        mosi_d    = 1'b0;
                        rx_data_d = rx_sh_q;
                        done_d    = 1'b1;
                        gap_d     = GW'(GAP - 1);
                        state_d   = ST_GAP;
                    end else begin
                        bit_d     = bit_q - 4'd1;
                        sck_d     = 1'b1;
                        tick_load = 1'b1;
                        state_d   = ST_SHIFT_HI;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            ready_q   <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ssel_q    <= 1'b1;
            rx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            ready_q   <= ready_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ssel_q    <= ssel_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign ssel      = ssel_q;
    assign rx_data   = rx_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_disp_spi_master.sv
// Bench for disp_spi_master: unit 0 runs DIV=6, unit 1 runs DIV=2; both
// GAP=12. A slave/display model watches the pins of each unit.
module tb_disp_spi_master;

    localparam int GAPV = 12;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n    [2];
    logic       valid_w  [2];
    logic [2:0] cmd_w    [2];
    logic [3:0] data_w   [2];
    logic       ready_w  [2];
    logic       sck_w    [2];
    logic       mosi_w   [2];
    logic       ssel_w   [2];
    logic       miso_w   [2];
    logic [7:0] rx_w     [2];
    logic       done_w   [2];

    disp_spi_master #(.DIV(6), .GAP(GAPV)) dut0 (
        .CLK_12_MHZ(clk), .RST_N(rst_n[0]), .cmd_valid(valid_w[0]),
        .cmd_ready(ready_w[0]), .cmd(cmd_w[0]), .data(data_w[0]),
        .sck(sck_w[0]), .mosi(mosi_w[0]), .ssel(ssel_w[0]), .miso(miso_w[0]),
        .rx_data(rx_w[0]), .done(done_w[0])
    );

    disp_spi_master #(.DIV(2), .GAP(GAPV)) dut1 (
        .CLK_12_MHZ(clk), .RST_N(rst_n[1]), .cmd_valid(valid_w[1]),
        .cmd_ready(ready_w[1]), .cmd(cmd_w[1]), .data(data_w[1]),
        .sck(sck_w[1]), .mosi(mosi_w[1]), .ssel(ssel_w[1]), .miso(miso_w[1]),
        .rx_data(rx_w[1]), .done(done_w[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          div_u   [2];
    int          acc     [2];
    int          fc0     [2];
    // slave / display model state
    int          nbits   [2];
    int          fr_cnt  [2];
    int          fr_bits [2];
    int          hi_run  [2];
    int          last_gap[2];
    int          done_cnt[2];
    int          mode_err[2];
    int          per_err [2];
    int          both_err[2];
    int          last_rise[2];
    logic [15:0] word    [2];
    logic [15:0] fr_word [2];
    logic        sck_p   [2];
    logic        ssel_p  [2];
    logic        mosi_hi [2];
    logic [7:0]  miso_pat[2];
    logic [3:0]  disp    [2][7];
    logic [3:0]  exp_disp[2][7];

    // Mode-0 slave: sample mosi on sck rise, drive miso while sck low,
    // decode a complete 16-bit frame into the digit register on ssel rise.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (done_w[u] === 1'b1) done_cnt[u]++;
            if (done_w[u] === 1'b1 && ready_w[u] === 1'b1) both_err[u]++;
            if (ssel_w[u] === 1'b1) hi_run[u]++;
            if (ssel_w[u] === 1'b0 && ssel_p[u] === 1'b1) begin
                last_gap[u] = hi_run[u];
                hi_run[u]   = 0;
                nbits[u]    = 0;
                word[u]     = '0;
            end
            if (ssel_w[u] === 1'b0 && sck_w[u] === 1'b1 && sck_p[u] === 1'b0) begin
                if (nbits[u] > 0 && (cyc - last_rise[u]) != 2 * div_u[u]) per_err[u]++;
                last_rise[u] = cyc;
                word[u]      = {word[u][14:0], mosi_w[u]};
                nbits[u]++;
                mosi_hi[u]   = mosi_w[u];
            end else if (sck_w[u] === 1'b1 && sck_p[u] === 1'b1 && mosi_w[u] !== mosi_hi[u]) begin
                mode_err[u]++;
            end
            if (ssel_w[u] === 1'b1 && ssel_p[u] === 1'b0) begin
                fr_cnt[u]++;
                fr_word[u] = word[u];
                fr_bits[u] = nbits[u];
                if (nbits[u] == 16 && word[u][15:11] == 5'd0 && word[u][7:4] == 4'd0 &&
                    word[u][10:8] >= 3'd1 && word[u][10:8] <= 3'd6)
                    disp[u][int'(word[u][10:8])] = word[u][3:0];
            end
            if (ssel_w[u] === 1'b0 && sck_w[u] === 1'b0)
                miso_w[u] = (nbits[u] >= 8 && nbits[u] < 16) ? miso_pat[u][15 - nbits[u]] : 1'b0;
            sck_p[u]  = sck_w[u];
            ssel_p[u] = ssel_w[u];
        end
    end

    task automatic start_frame(input int u, input logic [2:0] c, input logic [3:0] d,
                               input logic [7:0] pat);
        int n = 0;
        miso_pat[u] = pat;
        while (ready_w[u] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (ready_w[u] !== 1'b1) begin
            failures++; $display("FAIL start_ready_timeout u%0d got %b want 1", u, ready_w[u]);
        end
        valid_w[u] = 1'b1; cmd_w[u] = c; data_w[u] = d;
        acc[u] = cyc; fc0[u] = fr_cnt[u];
        @(negedge clk);
        valid_w[u] = 1'b0;
        cmd_w[u]   = 3'($urandom);
        data_w[u]  = 4'($urandom);
    endtask

    task automatic finish_frame(input int u, input logic [2:0] c, input logic [3:0] d,
                                input logic [7:0] pat);
        int n = 0;
        logic [15:0] exp_w;
        exp_w = {5'b0, c, 4'b0, d};
        while (done_w[u] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (done_w[u] !== 1'b1) begin
            failures++; $display("FAIL done_timeout u%0d got %b want 1", u, done_w[u]);
        end
        checks++;
        if (cyc - acc[u] != 1 + 33 * div_u[u]) begin
            failures++; $display("FAIL done_cycle u%0d got %0d want %0d", u, cyc - acc[u], 1 + 33 * div_u[u]);
        end
        checks++;
        if (rx_w[u] !== pat) begin
            failures++; $display("FAIL rx_data u%0d got %h want %h", u, rx_w[u], pat);
        end
        checks++;
        if (ssel_w[u] !== 1'b1) begin
            failures++; $display("FAIL ssel_at_done u%0d got %b want 1", u, ssel_w[u]);
        end
        n = 0;
        while (ready_w[u] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (ready_w[u] !== 1'b1 || cyc - acc[u] != 1 + 33 * div_u[u] + GAPV) begin
            failures++; $display("FAIL ready_cycle u%0d got %0d want %0d", u, cyc - acc[u], 1 + 33 * div_u[u] + GAPV);
        end
        checks++;
        if (fr_cnt[u] != fc0[u] + 1 || fr_bits[u] != 16) begin
            failures++; $display("FAIL frame_bits u%0d got frames=%0d bits=%0d want frames=%0d bits=16", u, fr_cnt[u] - fc0[u], fr_bits[u], 1);
        end
        checks++;
        if (fr_word[u] !== exp_w) begin
            failures++; $display("FAIL frame_word u%0d got %h want %h", u, fr_word[u], exp_w);
        end
        if (c >= 3'd1 && c <= 3'd6) exp_disp[u][int'(c)] = d;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (ready_w[u] !== 1'b1) begin failures++; $display("FAIL reset_ready u%0d got %b want 1", u, ready_w[u]); end
            checks++;
            if (sck_w[u] !== 1'b0) begin failures++; $display("FAIL reset_sck u%0d got %b want 0", u, sck_w[u]); end
            checks++;
            if (mosi_w[u] !== 1'b0) begin failures++; $display("FAIL reset_mosi u%0d got %b want 0", u, mosi_w[u]); end
            checks++;
            if (ssel_w[u] !== 1'b1) begin failures++; $display("FAIL reset_ssel u%0d got %b want 1", u, ssel_w[u]); end
            checks++;
            if (rx_w[u] !== 8'h00) begin failures++; $display("FAIL reset_rx u%0d got %h want 00", u, rx_w[u]); end
            checks++;
            if (done_w[u] !== 1'b0) begin failures++; $display("FAIL reset_done u%0d got %b want 0", u, done_w[u]); end
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_display(input int u, input string tag);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (disp[u][k] !== exp_disp[u][k]) begin
                failures++; $display("FAIL display_%s u%0d digit%0d got %h want %h", tag, u, k - 1, disp[u][k], exp_disp[u][k]);
            end
        end
    endtask

    task automatic test_single();
        start_frame(0, 3'd1, 4'hA, 8'h5A);
        finish_frame(0, 3'd1, 4'hA, 8'h5A);
        test_display(0, "single");
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            logic [2:0] c;
            logic [3:0] d;
            logic [7:0] p;
            c = 3'($urandom_range(0, 7));
            d = 4'($urandom);
            p = 8'($urandom);
            start_frame(0, c, d, p);
            finish_frame(0, c, d, p);
        end
        test_display(0, "random");
    endtask

    task automatic test_back_to_back();
        int n;
        int prev_a = 0;
        int fc = fr_cnt[0];
        miso_pat[0] = 8'h00;
        valid_w[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_w[0] = 3'(i + 1);
            data_w[0] = 4'(i);
            n = 0;
            while (ready_w[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
            checks++;
            if (ready_w[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready_timeout i%0d got %b want 1", i, ready_w[0]); end
            if (i > 0) begin
                checks++;
                if (cyc - prev_a != 1 + 33 * 6 + GAPV) begin
                    failures++; $display("FAIL b2b_spacing i%0d got %0d want %0d", i, cyc - prev_a, 1 + 33 * 6 + GAPV);
                end
            end
            prev_a = cyc;
            exp_disp[0][i + 1] = 4'(i);
            @(negedge clk); #1;
            if (i > 0) begin
                // GAP cycles plus the accept cycle on which cmd_ready is high
                checks++;
                if (last_gap[0] != GAPV + 1) begin
                    failures++; $display("FAIL b2b_gap i%0d got %0d want %0d", i, last_gap[0], GAPV + 1);
                end
            end
        end
        valid_w[0] = 1'b0;
        n = 0;
        while (ready_w[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (fr_cnt[0] != fc + 6 || fr_word[0] !== 16'h0605) begin
            failures++; $display("FAIL b2b_frames got %0d last=%h want 6 last=0605", fr_cnt[0] - fc, fr_word[0]);
        end
        test_display(0, "b2b");
    endtask

    task automatic test_ignore_busy();
        int n = 0;
        logic [7:0] p;
        p = 8'($urandom);
        start_frame(0, 3'd4, 4'h9, p);
        while (!(nbits[0] == 3 && sck_w[0] === 1'b1) && n < 500) begin @(negedge clk); n++; end
        valid_w[0] = 1'b1; cmd_w[0] = 3'd2; data_w[0] = 4'hF;
        checks++;
        if (ready_w[0] !== 1'b0 || sck_w[0] !== 1'b1) begin
            failures++; $display("FAIL busy_ready got ready=%b sck=%b want ready=0 sck=1", ready_w[0], sck_w[0]);
        end
        @(negedge clk);
        valid_w[0] = 1'b0;
        finish_frame(0, 3'd4, 4'h9, p);
        test_display(0, "ignore");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int dc;
        logic [7:0] p;
        p = 8'($urandom);
        start_frame(0, 3'd5, 4'h3, 8'hFF);
        while (nbits[0] != 7 && n < 500) begin @(negedge clk); n++; end
        dc = done_cnt[0];
        rst_n[0] = 1'b0;
        #1;
        checks++;
        if (ssel_w[0] !== 1'b1 || sck_w[0] !== 1'b0 || mosi_w[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_pins got ssel=%b sck=%b mosi=%b want 1 0 0", ssel_w[0], sck_w[0], mosi_w[0]);
        end
        checks++;
        if (rx_w[0] !== 8'h00 || done_w[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_rx got rx=%h done=%b want 00 0", rx_w[0], done_w[0]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt[0] != dc || fr_bits[0] != 7) begin
            failures++; $display("FAIL midrst_abandon got dones=%0d bits=%0d want 0 7", done_cnt[0] - dc, fr_bits[0]);
        end
        rst_n[0] = 1'b1;
        @(negedge clk);
        start_frame(0, 3'd6, 4'h7, p);
        finish_frame(0, 3'd6, 4'h7, p);
        test_display(0, "midrst");
    endtask

    task automatic test_div2();
        start_frame(1, 3'd0, 4'hC, 8'hC3);
        finish_frame(1, 3'd0, 4'hC, 8'hC3);
        checks++;
        if (per_err[1] != 0 || last_rise[1] == 0) begin
            failures++; $display("FAIL div2_period got errs=%0d want 0", per_err[1]);
        end
        test_display(1, "div2");
    endtask

    initial begin
        div_u[0] = 6; div_u[1] = 2;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; valid_w[u] = 1'b0; cmd_w[u] = '0; data_w[u] = '0;
            miso_w[u] = 1'b0; miso_pat[u] = '0;
            acc[u] = 0; fc0[u] = 0; nbits[u] = 0; fr_cnt[u] = 0; fr_bits[u] = 0;
            hi_run[u] = 0; last_gap[u] = 0; done_cnt[u] = 0; mode_err[u] = 0;
            per_err[u] = 0; both_err[u] = 0; last_rise[u] = 0;
            word[u] = '0; fr_word[u] = '0; sck_p[u] = 1'b0; ssel_p[u] = 1'b1; mosi_hi[u] = 1'b0;
            for (int k = 0; k < 7; k++) begin disp[u][k] = '0; exp_disp[u][k] = '0; end
        end
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_div2();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (mode_err[u] != 0 || per_err[u] != 0) begin
                failures++; $display("FAIL spi_mode u%0d got mode_errs=%0d period_errs=%0d want 0 0", u, mode_err[u], per_err[u]);
            end
            checks++;
            if (both_err[u] != 0) begin
                failures++; $display("FAIL done_and_ready u%0d got %0d want 0", u, both_err[u]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
